// File: rtl/rv_pc_pkg.sv
// rv_pc_pkg: control-op encodings, FSM states and RV32 immediate extraction
// shared by the next-PC generator and its branch comparator.
package rv_pc_pkg;

    typedef enum logic [3:0] {
        OP_JAL  = 4'b0000,
        OP_JALR = 4'b0001,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BLT  = 4'b1100,
        OP_BGE  = 4'b1101,
        OP_BLTU = 4'b1110,
        OP_BGEU = 4'b1111
    } op_e;

    typedef enum logic {ST_FLUSH, ST_RUN} state_e;

    function automatic logic signed [31:0] imm_j(input logic [31:0] instr);
        return $signed({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] instr);
        return $signed({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
    endfunction

    function automatic logic signed [31:0] imm_i(input logic [31:0] instr);
        return $signed({{20{instr[31]}}, instr[31:20]});
    endfunction

endpackage

// File: rtl/rv_pc_gen_if.sv
// rv_pc_gen_if: decode-side request and fetch-side PC bundle for rv_pc_gen;
// MISALIGN_TRAP_EN adds the misalign pulse.
interface rv_pc_gen_if #(parameter int XLEN = 32);
    logic            enable;
    logic            stall;
    logic            op_valid;
    logic [3:0]      op;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            trap_req;
    logic [XLEN-1:0] trap_vec;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_addr;
    logic            link_valid;
    logic            redirect;
    logic            flush;
`ifdef MISALIGN_TRAP_EN
    logic            misalign;
`endif

    modport master (
`ifdef MISALIGN_TRAP_EN
        input  misalign,
`endif
        output enable, stall, op_valid, op, instr, rs1, rs2, trap_req, trap_vec,
        input  pc, link_addr, link_valid, redirect, flush
    );

    modport slave (
`ifdef MISALIGN_TRAP_EN
        output misalign,
`endif
        input  enable, stall, op_valid, op, instr, rs1, rs2, trap_req, trap_vec,
        output pc, link_addr, link_valid, redirect, flush
    );
endinterface

// File: rtl/rv_branch_cmp.sv
// rv_branch_cmp: combinational taken decision; jumps are always taken,
// unknown op codes never are.
module rv_branch_cmp
    import rv_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);
    logic eq, lt, ltu;

    always_comb begin
        eq  = rs1_i == rs2_i;
        lt  = $signed(rs1_i) < $signed(rs2_i);
        ltu = rs1_i < rs2_i;
        taken_o = (op_i == OP_JAL || op_i == OP_JALR) ? 1'b1 :
                  op_i == OP_BEQ  ? eq   :
                  op_i == OP_BNE  ? !eq  :
                  op_i == OP_BLT  ? lt   :
                  op_i == OP_BGE  ? !lt  :
                  op_i == OP_BLTU ? ltu  :
                  op_i == OP_BGEU ? !ltu : 1'b0;
    end
endmodule

// File: rtl/rv_pc_gen.sv
// rv_pc_gen: next-PC generator with branch resolution, trap redirect and a
// counted flush window. Optional MISALIGN_TRAP_EN traps bit[1]-misaligned targets.
module rv_pc_gen
    import rv_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter bit              WORD_ADDR    = 1'b1,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    rv_pc_gen_if.slave  pc_if
);
    localparam logic [XLEN-1:0] STEP = WORD_ADDR ? XLEN'(1) : XLEN'(4);
    localparam logic [3:0]      FC   = 4'(FLUSH_CYCLES);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d, link_q, link_d;
    logic            link_v_q, link_v_d, redir_q, redir_d;
    logic            taken, is_link;
    logic signed [XLEN-1:0] imm_jb, imm_jr, off;
    logic [XLEN-1:0] jalr_byte, tgt;
`ifdef MISALIGN_TRAP_EN
    logic            mis, mis_q, mis_d;
`endif

    rv_branch_cmp #(.XLEN(XLEN)) u_cmp (
        .op_i    (pc_if.op),
        .rs1_i   (pc_if.rs1),
        .rs2_i   (pc_if.rs2),
        .taken_o (taken)
    );

    always_comb begin
        is_link   = pc_if.op == OP_JAL || pc_if.op == OP_JALR;
        imm_jb    = pc_if.op == OP_JAL ? XLEN'(imm_j(pc_if.instr)) : XLEN'(imm_b(pc_if.instr));
        imm_jr    = XLEN'(imm_i(pc_if.instr));
        off       = WORD_ADDR ? imm_jb >>> 2 : imm_jb;
        jalr_byte = (pc_if.rs1 + imm_jr) & {{(XLEN-1){1'b1}}, 1'b0};
        tgt       = pc_if.op == OP_JALR ? (WORD_ADDR ? jalr_byte >> 2 : jalr_byte) : pc_q + off;
`ifdef MISALIGN_TRAP_EN
        // word-mode JAL/branch targets are always word aligned in bytes
        mis       = WORD_ADDR ? (pc_if.op == OP_JALR && jalr_byte[1]) : tgt[1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= FC;
            pc_q     <= RESET_VECTOR;
            link_q   <= '0;
            link_v_q <= 1'b0;
            redir_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            link_q   <= link_d;
            link_v_q <= link_v_d;
            redir_q  <= redir_d;
`ifdef MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        link_d   = link_q;
        link_v_d = link_v_q;
        redir_d  = redir_q;
`ifdef MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        if (pc_if.enable) begin
            link_v_d = 1'b0;
            redir_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_d    = 1'b0;
`endif
            if (pc_if.trap_req) begin
                pc_d    = pc_if.trap_vec;
                redir_d = 1'b1;
                state_d = ST_FLUSH;
                cnt_d   = FC;
            end else if (!pc_if.stall) begin
                if (state_q == ST_FLUSH) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = cnt_q <= 4'd1 ? ST_RUN : ST_FLUSH;
                end else if (pc_if.op_valid && taken) begin
`ifdef MISALIGN_TRAP_EN
                    pc_d    = mis ? pc_if.trap_vec : tgt;
                    mis_d   = mis;
`else
                    pc_d    = tgt;
`endif
                    redir_d  = 1'b1;
                    state_d  = ST_FLUSH;
                    cnt_d    = FC;
                    link_d   = is_link ? pc_q + STEP : link_q;
                    link_v_d = is_link;
                end else begin
                    pc_d = pc_q + STEP;
                end
            end
        end
    end

    always_comb begin
        pc_if.pc         = pc_q;
        pc_if.link_addr  = link_q;
        pc_if.link_valid = link_v_q;
        pc_if.redirect   = redir_q;
        pc_if.flush      = state_q == ST_FLUSH;
`ifdef MISALIGN_TRAP_EN
        pc_if.misalign   = mis_q;
`endif
    end
endmodule

// File: tb/tb_rv_pc_gen.sv
// tb_rv_pc_gen: directed checks of rv_pc_gen in word mode (dut_a) and byte
// mode (dut_b); MISALIGN_TRAP_EN switches the misaligned-JAL expectation.
module tb_rv_pc_gen;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_pc_gen_if #(.XLEN(32)) a_if ();
    rv_pc_gen_if #(.XLEN(32)) b_if ();

    rv_pc_gen #(.XLEN(32), .WORD_ADDR(1'b1), .RESET_VECTOR(32'h100), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .pc_if(a_if)
    );
    rv_pc_gen #(.XLEN(32), .WORD_ADDR(1'b0), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .pc_if(b_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] r = '0;
        r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12];
        return r;
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] r = '0;
        r[31] = imm[12]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; r[7] = imm[11];
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        a_if.enable = 1; a_if.stall = 0; a_if.op_valid = 0; a_if.op = 0; a_if.instr = 0;
        a_if.rs1 = 0; a_if.rs2 = 0; a_if.trap_req = 0; a_if.trap_vec = 0;
        b_if.enable = 1; b_if.stall = 0; b_if.op_valid = 0; b_if.op = 0; b_if.instr = 0;
        b_if.rs1 = 0; b_if.rs2 = 0; b_if.trap_req = 0; b_if.trap_vec = 0;
        #2;
        check("rst_pc", a_if.pc, 32'h100);
        check("rst_flush", a_if.flush, 1);
        check("rst_link", a_if.link_addr, 0);
        check("rst_lv", a_if.link_valid, 0);
        check("rst_redir", a_if.redirect, 0);
        check("rst_pc_b", b_if.pc, 0);
        @(negedge clk) rst = 1'b0;
        step; check("flush1", a_if.flush, 1); check("flush1_pc", a_if.pc, 32'h100);
        step; check("flush_end", a_if.flush, 0); check("hold_pc", a_if.pc, 32'h100);
        step; check("seq1", a_if.pc, 32'h101);
        step; check("seq2", a_if.pc, 32'h102);
        // move to 0x200 through a trap
        a_if.trap_req = 1; a_if.trap_vec = 32'h200;
        step; check("trap_pc", a_if.pc, 32'h200); check("trap_redir", a_if.redirect, 1);
        a_if.trap_req = 0;
        step; check("trap_redir_end", a_if.redirect, 0); check("trap_flush", a_if.flush, 1);
        step; check("trap_run", a_if.flush, 0); check("trap_pc_hold", a_if.pc, 32'h200);
        // JAL +16 bytes = +4 words
        a_if.op_valid = 1; a_if.op = 4'b0000; a_if.instr = enc_j(16);
        step;
        check("jal_pc", a_if.pc, 32'h204); check("jal_link", a_if.link_addr, 32'h201);
        check("jal_lv", a_if.link_valid, 1); check("jal_redir", a_if.redirect, 1);
        check("jal_flush", a_if.flush, 1);
        a_if.op = 4'b1000; a_if.instr = enc_b(8); a_if.rs1 = 7; a_if.rs2 = 7;
        step; check("beq_ign1", a_if.pc, 32'h204); check("jal_lv_end", a_if.link_valid, 0);
        check("jal_flush2", a_if.flush, 1);
        step; check("beq_ign2", a_if.pc, 32'h204); check("jal_flush_end", a_if.flush, 0);
        step; check("beq_taken", a_if.pc, 32'h206); check("beq_redir", a_if.redirect, 1);
        a_if.op_valid = 0;
        step(2); check("beq_settle", a_if.pc, 32'h206);
        a_if.op_valid = 1; a_if.op = 4'b1100; a_if.rs1 = 32'hFFFFFFFF; a_if.rs2 = 1;
        step; check("blt_taken", a_if.pc, 32'h208);
        a_if.op_valid = 0;
        step(2);
        a_if.op_valid = 1; a_if.op = 4'b1110;
        step; check("bltu_nt", a_if.pc, 32'h209); check("bltu_redir", a_if.redirect, 0);
        check("bltu_flush", a_if.flush, 0);
        a_if.op = 4'b1101; a_if.rs1 = 5; a_if.rs2 = 5; a_if.instr = enc_b(-4);
        step; check("bge_eq", a_if.pc, 32'h208);
        a_if.op_valid = 0;
        step(2);
        a_if.op_valid = 1; a_if.op = 4'b0010;
        step; check("unk_seq", a_if.pc, 32'h209); check("unk_redir", a_if.redirect, 0);
        a_if.op_valid = 0;
        // stall stretches the flush window
        a_if.trap_req = 1; a_if.trap_vec = 32'h300;
        step; check("trap2_pc", a_if.pc, 32'h300);
        a_if.trap_req = 0; a_if.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step; check("stall_flush", a_if.flush, 1); check("stall_pc", a_if.pc, 32'h300);
        end
        a_if.stall = 0;
        step; check("post_stall_flush", a_if.flush, 1);
        step; check("post_stall_run", a_if.flush, 0); check("post_stall_pc", a_if.pc, 32'h300);
        a_if.stall = 1; a_if.op_valid = 1; a_if.op = 4'b0000; a_if.instr = enc_j(16);
        step; check("stall_op_held", a_if.pc, 32'h300); check("stall_op_redir", a_if.redirect, 0);
        a_if.trap_req = 1; a_if.trap_vec = 32'h400;
        step; check("trap_in_stall", a_if.pc, 32'h400); check("trap_in_stall_redir", a_if.redirect, 1);
        check("trap_in_stall_lv", a_if.link_valid, 0);
        a_if.trap_req = 0; a_if.stall = 0; a_if.op_valid = 0;
        // enable=0 freezes everything, pulses included
        a_if.enable = 0;
        step(2); check("en_redir_hold", a_if.redirect, 1); check("en_pc_hold", a_if.pc, 32'h400);
        check("en_flush_hold", a_if.flush, 1);
        a_if.enable = 1;
        step; check("en_redir_end", a_if.redirect, 0); check("en_flush_cnt", a_if.flush, 1);
        step; check("en_run", a_if.flush, 0);
        // byte-mode wrap and JALR
        b_if.trap_req = 1; b_if.trap_vec = 32'hFFFFFFFC;
        step; b_if.trap_req = 0;
        step(2); check("b_pre_wrap", b_if.pc, 32'hFFFFFFFC);
        step; check("b_wrap", b_if.pc, 32'h0);
        b_if.op_valid = 1; b_if.op = 4'b0001; b_if.rs1 = 32'h1001; b_if.instr = 0;
        step; check("jalr_pc", b_if.pc, 32'h1000); check("jalr_link", b_if.link_addr, 32'h4);
        check("jalr_lv", b_if.link_valid, 1);
        b_if.op_valid = 0; b_if.trap_vec = 32'h5000;
        step(2); check("jalr_settle", b_if.pc, 32'h1000);
        b_if.op_valid = 1; b_if.op = 4'b0000; b_if.instr = enc_j(2);
        step;
`ifdef MISALIGN_TRAP_EN
        check("mis_pc", b_if.pc, 32'h5000); check("mis_pulse", b_if.misalign, 1);
`else
        check("jal2_pc", b_if.pc, 32'h1002);
`endif
        b_if.op_valid = 0;
        step;
`ifdef MISALIGN_TRAP_EN
        check("mis_end", b_if.misalign, 0);
`endif
        check("jal2_redir_end", b_if.redirect, 0);
        // asynchronous reset mid-run
        rst = 1'b1;
        #2;
        check("arst_pc", a_if.pc, 32'h100); check("arst_flush", a_if.flush, 1);
        check("arst_link", b_if.link_addr, 0); check("arst_pc_b", b_if.pc, 0);
        @(negedge clk) rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_pc_gen.md
# rv_pc_gen

Parametrised next-PC generator and branch-resolution unit for the RV32 core fetch stage. It generalises the single-width word-addressed PC unit:
- XLEN, addressing mode, reset vector and flush depth are configurable.
- It adds trap redirection and a counted multi-cycle flush window that suppresses wrong-path control ops.

It sits between decode (control-op request, operands) and the instruction memory address port.

## Interface
- XLEN, 32, datapath and PC width
- WORD_ADDR, 1, 1: PC counts words (step 1, offsets arithmetically shifted right 2); 0: PC counts bytes (step 4, offsets as-is)
- RESET_VECTOR, 0, PC value loaded on reset
- FLUSH_CYCLES, 2, flush window length after any redirect (1..15)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  global run; 0 freezes all state
- stall  in  1  pipeline busy; holds PC and flush counter
- op_valid  in  1  decode presents a control op this cycle
- op  in  4  0000 JAL, 0001 JALR, 1000 BEQ, 1001 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU; other codes are treated as sequential
- instr  in  32  instruction word carrying the immediate
- rs1, rs2  in  XLEN  source operands
- trap_req  in  1  exception/interrupt redirect request
- trap_vec  in  XLEN  trap target
- pc  out  XLEN  current fetch address
- link_addr  out  XLEN  return address for JAL/JALR
- link_valid  out  1  one-cycle pulse: link_addr updated
- redirect  out  1  one-cycle pulse: PC was loaded non-sequentially
- flush  out  1  discard in-flight fetch/decode

## Operation
- Immediates follow RV32 encoding:
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - I-type: instr[31:20]
  - All are sign-extended to XLEN.
- Targets:
  - JAL/branch: target = pc + off.
  - JALR: target = (rs1 + imm) & ~1. With WORD_ADDR=1, JALR converts the byte result to a word address (>>2).
  - off = imm (WORD_ADDR=0) or imm>>>2 (WORD_ADDR=1).
  - All sums wrap modulo 2^XLEN.
- Comparisons:
  - BLT/BGE are true two's-complement signed.
  - BLTU/BGEU are unsigned.
  - BGE/BGEU are taken on equality.
- Link: link_addr = pc + STEP, registered on JAL/JALR acceptance; link_valid pulses in the same cycle.
- States:
  - FLUSH: entered from reset with counter = FLUSH_CYCLES. In FLUSH, flush=1 and op_valid is ignored. The counter decrements each non-stalled enabled cycle; at 1 → RUN.
  - RUN: a taken op or trap loads target, pulses redirect, and enters FLUSH with counter = FLUSH_CYCLES. A not-taken or sequential op advances pc by STEP.
- Priority, highest first: rst, !enable, trap_req, stall, FLUSH suppression, op_valid, sequential increment.
  - trap_req overrides stall and is honoured in FLUSH, restarting the counter.

## Timing
- Reset values:
  - pc = RESET_VECTOR
  - link_addr = 0
  - link_valid = 0, redirect = 0
  - flush = 1
  - state FLUSH, counter = FLUSH_CYCLES
- Redirect latency is one cycle: op sampled at edge N, pc = target after edge N. redirect is high after edge N for one cycle.
- flush is high from edge N through FLUSH_CYCLES cycles (stall cycles extend it).
- enable=0: all registers hold, including flush and counter. Pulse outputs hold their registered value.
- stall=1 with op_valid: op is not consumed. Decode must hold it.
- rst asserted mid-operation immediately forces reset values, independent of clk.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A taken JAL/branch/JALR whose byte target has bit[1] set does not redirect to target. It redirects to trap_vec instead.
  - It additionally drives output misalign (1 bit, registered, one-cycle pulse, reset 0).
- Undefined: no misalign port; bit[1] is ignored, as bit[0] is already cleared; target is loaded unchanged.

## Structure
- Package rv_pc_pkg holds:
  - the op encoding enum (OP_JAL … OP_BGEU)
  - state enum (ST_FLUSH, ST_RUN)
  - immediate-extraction functions
- One sub-module rv_branch_cmp: combinational taken decision from op, rs1, rs2.
- Target mux, PC register, counter and FSM stay in rv_pc_gen.

## Test plan
- Reset, XLEN=32, WORD_ADDR=1, RESET_VECTOR=0x100, FLUSH_CYCLES=2:
  - pc=0x100, flush=1 for 2 cycles after rst release.
  - Then pc increments 0x101, 0x102.
- JAL, imm=+16 at pc=0x200 (WORD_ADDR=1):
  - pc=0x204, link_addr=0x201, redirect and link_valid pulse.
  - flush 2 cycles; a BEQ presented during flush is ignored.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken. BLTU same operands → not taken, pc+1. BGE rs1=rs2=5 → taken.
- stall held 3 cycles during flush window: pc holds, flush stays high 3+2 cycles. trap_req during stall → pc=trap_vec next cycle.
- Wrap: WORD_ADDR=0, pc=0xFFFFFFFC, sequential → pc=0x00000000. JALR rs1=0x1001, imm=0 → pc=0x1000.
- MISALIGN_TRAP_EN, WORD_ADDR=0, JAL imm=+2 → pc=trap_vec, misalign pulses 1 cycle. Without the macro → pc=pc+2.
